// File: rtl/ex_issue_ctrl.sv
`timescale 1ns / 1ps
// ex_issue_ctrl: sequencing controller for the execute datapath.
//
// Accepts one decoded instruction at a time from decode over a valid/ready
// handshake and latches its operands onto the ex_* outputs. The operands
// feed the external execute stage for EX_CYCLES settle cycles. After that
// the ALU/branch results are captured into a holding register for
// memory/writeback. A taken branch raises a one-cycle PC redirect. A
// synchronous flush kills the in-flight instruction.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   flush               synchronous kill of the in-flight instruction
//   in_*                decode-side handshake and instruction fields
//   ex_*  (outputs)     latched operands/controls to the execute stage
//   ex_*  (inputs)      execute-stage ALU result and branch decision/target
//   out_*               result holding register and writeback handshake
//   redirect_*          one-cycle taken-branch PC redirect
//   busy                controller is not idle
//
// Optional feature (macro EX_PERF_CNT_EN): adds the perf_retired and
// perf_br_taken 64-bit event counters.
module ex_issue_ctrl #(
   parameter int EX_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_rs1_data,
   input  logic [63:0] in_rs2_data,
   input  logic [63:0] in_imm,
   input  logic [2:0]  in_funct3,
   input  logic [6:0]  in_funct7,
   input  logic        in_alu_src_b_sel,
   input  logic        in_branch,
   input  logic [63:0] in_pc,
   input  logic [4:0]  in_rd,
   input  logic        in_reg_write,
   output logic [63:0] ex_rs1_data,
   output logic [63:0] ex_rs2_data,
   output logic [63:0] ex_immediate,
   output logic [63:0] ex_pc,
   output logic [2:0]  ex_funct3,
   output logic [6:0]  ex_funct7,
   output logic        ex_alu_src_b_sel,
   output logic        ex_branch,
   input  logic [63:0] ex_alu_result,
   input  logic        ex_branch_taken,
   input  logic [63:0] ex_branch_target,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_alu_result,
   output logic [63:0] out_pc,
   output logic [4:0]  out_rd,
   output logic        out_reg_write,
   output logic        redirect_valid,
   output logic [63:0] redirect_pc,
   output logic        busy
`ifdef EX_PERF_CNT_EN
   ,
   output logic [63:0] perf_retired,
   output logic [63:0] perf_br_taken
`endif
);

   // Settle counts below one behave as one.
   localparam int unsigned EffCycles = (EX_CYCLES < 1) ? 1 : EX_CYCLES;
   localparam int unsigned CntW      = $clog2(EffCycles) + 1;
   localparam logic [CntW-1:0] CntLoad = CntW'(EffCycles - 1);

   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StHold
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [4:0]      rd_q;
   logic            reg_write_q;
   logic            accept;
   logic            capture;
   logic            out_valid_d;
   logic            redirect_d;

   always_comb begin
      in_ready    = 1'b0;
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid;

      unique case (state_q)
         StIdle:  in_ready = 1'b1;
         StExec:  in_ready = 1'b0;
         // No accept during the redirect pulse keeps wrong-path work out.
         StHold:  in_ready = out_ready & ~redirect_valid;
         default: in_ready = 1'b0;
      endcase

      accept  = in_valid & in_ready & ~flush;
      capture = (state_q == StExec) && (cnt_q == '0) && !flush;

      if (flush) begin
         state_d     = StIdle;
         out_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  state_d = StExec;
                  cnt_d   = CntLoad;
               end
            end
            StExec: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CntW'(1);
               end else begin
                  state_d     = StHold;
                  out_valid_d = 1'b1;
               end
            end
            StHold: begin
               if (out_ready) begin
                  out_valid_d = 1'b0;
                  if (accept) begin
                     state_d = StExec;
                     cnt_d   = CntLoad;
                  end else begin
                     state_d = StIdle;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end

      // Pulse lasts one cycle: nothing holds it beyond the capture edge.
      redirect_d = capture & ex_branch & ex_branch_taken;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= StIdle;
         cnt_q            <= '0;
         rd_q             <= '0;
         reg_write_q      <= 1'b0;
         ex_rs1_data      <= '0;
         ex_rs2_data      <= '0;
         ex_immediate     <= '0;
         ex_pc            <= '0;
         ex_funct3        <= '0;
         ex_funct7        <= '0;
         ex_alu_src_b_sel <= 1'b0;
         ex_branch        <= 1'b0;
         out_valid        <= 1'b0;
         out_alu_result   <= '0;
         out_pc           <= '0;
         out_rd           <= '0;
         out_reg_write    <= 1'b0;
         redirect_valid   <= 1'b0;
         redirect_pc      <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         out_valid      <= out_valid_d;
         redirect_valid <= redirect_d;
         if (accept) begin
            ex_rs1_data      <= in_rs1_data;
            ex_rs2_data      <= in_rs2_data;
            ex_immediate     <= in_imm;
            ex_pc            <= in_pc;
            ex_funct3        <= in_funct3;
            ex_funct7        <= in_funct7;
            ex_alu_src_b_sel <= in_alu_src_b_sel;
            ex_branch        <= in_branch;
            rd_q             <= in_rd;
            reg_write_q      <= in_reg_write;
         end
         if (capture) begin
            out_alu_result <= ex_alu_result;
            out_pc         <= ex_pc;
            out_rd         <= rd_q;
            // Branches never write a destination register.
            out_reg_write  <= reg_write_q & ~ex_branch;
         end
         if (redirect_d) begin
            redirect_pc <= ex_branch_target;
         end
      end
   end

   assign busy = (state_q != StIdle);

`ifdef EX_PERF_CNT_EN
   // Event counters ignore flush; they only observe the output handshakes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_retired  <= '0;
         perf_br_taken <= '0;
      end else begin
         if (out_valid & out_ready) begin
            perf_retired <= perf_retired + 64'd1;
         end
         if (redirect_valid) begin
            perf_br_taken <= perf_br_taken + 64'd1;
         end
      end
   end
`endif

endmodule
